// File: rtl/fmul_pkg.sv
// rtl/fmul_pkg.sv - binary32 multiplier back-end constants and stage-1 register layout.
package fmul_pkg;

    localparam int BIAS    = 127;
    localparam int EXP_MAX = 255;
    localparam int MANT_W  = 23;
    localparam int PROD_W  = 48;
    localparam int EXP_W   = 10;

    typedef struct packed {
        logic                    sign;
        logic                    zero;
        logic signed [EXP_W-1:0] e;
        logic [MANT_W-1:0]       mant;
        logic                    g;
        logic                    s;
    } fmul_s1_t;

endpackage

// File: rtl/fmul_rne_round.sv
// rtl/fmul_rne_round.sv - combinational round-to-nearest-even on a 23-bit mantissa.
module fmul_rne_round
    import fmul_pkg::*;
(
    input  logic [MANT_W-1:0]       mant,
    input  logic                    g,
    input  logic                    s,
    input  logic signed [EXP_W-1:0] e,
    output logic [MANT_W-1:0]       mant_rnd,
    output logic signed [EXP_W-1:0] e_rnd,
    output logic                    inexact
);

    logic          round_up;
    logic [MANT_W:0] sum;

    assign round_up = g & (s | mant[0]);
    assign sum      = {1'b0, mant} + {{MANT_W{1'b0}}, round_up};

    // A carry out leaves the low bits at zero, which is exactly the renormalized
    // mantissa; for a subnormal (e=0) the same bump lands on e=1.
    assign mant_rnd = sum[MANT_W-1:0];
    assign e_rnd    = sum[MANT_W] ? e + 10'sd1 : e;
    assign inexact  = g | s;

endmodule

// File: rtl/fmul_round_pack.sv
// rtl/fmul_round_pack.sv - normalize, RNE round and pack binary32; FMUL_SUBNORMAL_EN enables gradual underflow.
module fmul_round_pack
    import fmul_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_sign,
    input  logic [PROD_W-1:0]       in_product,
    input  logic signed [EXP_W-1:0] in_exp,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [31:0]             result,
    output logic                    flag_overflow,
    output logic                    flag_underflow,
    output logic                    flag_inexact
);

    fmul_s1_t s1_d;
    fmul_s1_t s1_q;
    logic     s1_valid;
    logic     s1_load;
    logic     s2_load;

    assign in_ready = !s1_valid | !out_valid | out_ready;
    assign s1_load  = in_valid & in_ready;
    assign s2_load  = s1_valid & (!out_valid | out_ready);

    always_comb begin
        s1_d.sign = in_sign;
        s1_d.zero = (in_product[PROD_W-1:PROD_W-2] == 2'b00);
        if (in_product[PROD_W-1]) begin
            s1_d.mant = in_product[46:24];
            s1_d.g    = in_product[23];
            s1_d.s    = |in_product[22:0];
            s1_d.e    = in_exp + 10'sd1;
        end else begin
            s1_d.mant = in_product[45:23];
            s1_d.g    = in_product[22];
            s1_d.s    = |in_product[21:0];
            s1_d.e    = in_exp;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_q     <= '0;
        end else begin
            if (s1_load) begin
                s1_valid <= 1'b1;
                s1_q     <= s1_d;
            end else if (s2_load) begin
                s1_valid <= 1'b0;
            end
        end
    end

    logic                    tiny;
    logic [MANT_W-1:0]       r_mant;
    logic                    r_g;
    logic                    r_s;
    logic signed [EXP_W-1:0] r_e;

    assign tiny = !s1_q.zero && ($signed(s1_q.e) <= $signed(10'sd0));

`ifdef FMUL_SUBNORMAL_EN
    logic signed [EXP_W-1:0] sh_full;
    logic [4:0]              sh;
    logic [49:0]             ext;

    // {hidden, mant, g} sits in ext[49:25]; everything shifted below bit 25 becomes sticky.
    always_comb begin
        sh_full = 10'sd1 - s1_q.e;
        sh      = (sh_full > 10'sd25) ? 5'd25 : sh_full[4:0];
        ext     = {1'b1, s1_q.mant, s1_q.g, 25'b0} >> sh;
        r_mant  = s1_q.mant;
        r_g     = s1_q.g;
        r_s     = s1_q.s;
        r_e     = s1_q.e;
        if (tiny) begin
            r_mant = ext[48:26];
            r_g    = ext[25];
            r_s    = s1_q.s | (|ext[24:0]);
            r_e    = '0;
        end
    end
`else
    always_comb begin
        r_mant = s1_q.mant;
        r_g    = s1_q.g;
        r_s    = s1_q.s;
        r_e    = s1_q.e;
    end
`endif

    logic [MANT_W-1:0]       rnd_mant;
    logic signed [EXP_W-1:0] rnd_e;
    logic                    rnd_inexact;

    fmul_rne_round u_round (
        .mant     (r_mant),
        .g        (r_g),
        .s        (r_s),
        .e        (r_e),
        .mant_rnd (rnd_mant),
        .e_rnd    (rnd_e),
        .inexact  (rnd_inexact)
    );

    logic [31:0] res_d;
    logic        ov_d;
    logic        uf_d;
    logic        ix_d;

    always_comb begin
        res_d = {s1_q.sign, rnd_e[7:0], rnd_mant};
        ov_d  = 1'b0;
        uf_d  = 1'b0;
        ix_d  = rnd_inexact;
        if (s1_q.zero) begin
            res_d = {s1_q.sign, 31'b0};
            ix_d  = 1'b0;
        end else if (tiny) begin
`ifdef FMUL_SUBNORMAL_EN
            uf_d = rnd_inexact;
`else
            res_d = {s1_q.sign, 31'b0};
            uf_d  = 1'b1;
            ix_d  = 1'b1;
`endif
        end else if (rnd_e >= EXP_MAX) begin
            res_d = {s1_q.sign, 8'hFF, 23'b0};
            ov_d  = 1'b1;
            ix_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid      <= 1'b0;
            result         <= '0;
            flag_overflow  <= 1'b0;
            flag_underflow <= 1'b0;
            flag_inexact   <= 1'b0;
        end else begin
            if (s2_load) begin
                out_valid      <= 1'b1;
                result         <= res_d;
                flag_overflow  <= ov_d;
                flag_underflow <= uf_d;
                flag_inexact   <= ix_d;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
